// File: rtl/uart_tx_fsm_if.sv
// uart_tx_fsm_if: byte handshake between a sender (master) and the UART transmitter (slave).
//   tx_data  [7:0]  byte offered by the sender
//   tx_valid        sender requests transmission of tx_data
//   tx_ready        transmitter can accept a byte this cycle
interface uart_tx_fsm_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fsm.sv
// uart_tx_fsm: 8N1 UART transmitter (8E1 when UART_TX_PARITY_EN is defined), LSB first.
//   clock    single clock, all state updates on posedge
//   reset    synchronous, active-high
//   bus      uart_tx_fsm_if.slave: tx_data/tx_valid in, tx_ready out (high only in IDLE)
//   tx       registered serial line, idles at 1
//   tx_done  one-cycle pulse in the first IDLE cycle after the stop bit
// Bit period is CLKS_PER_SAMPLE*OVERSAMPLE clocks.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_fsm #(
    parameter int CLKS_PER_SAMPLE = 4,
    parameter int OVERSAMPLE      = 16
) (
    input  logic         clock,
    input  logic         reset,
    uart_tx_fsm_if.slave bus,
    output logic         tx,
    output logic         tx_done
);
    localparam int CW = CLKS_PER_SAMPLE > 1 ? $clog2(CLKS_PER_SAMPLE) : 1;
    localparam int SW = OVERSAMPLE > 1 ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_SAMPLE - 1);
    localparam logic [SW-1:0] SMP_LAST = SW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] clk_cnt, clk_cnt_n;
    logic [SW-1:0] smp_cnt, smp_cnt_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shift_reg, shift_n;
    logic          tx_n, done_n, run;
    logic          tick, bit_end;
`ifdef UART_TX_PARITY_EN
    logic          par, par_n;
`endif

    assign tick         = clk_cnt == CLK_LAST;
    assign bit_end      = tick && smp_cnt == SMP_LAST;
    assign bus.tx_ready = state == IDLE;

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift_reg;
        done_n    = 1'b0;
        run       = 1'b0;
        clk_cnt_n = '0;
        smp_cnt_n = '0;
`ifdef UART_TX_PARITY_EN
        par_n     = par;
`endif
        case (state)
            IDLE: begin
                bit_cnt_n = '0;
                if (bus.tx_valid) begin
                    state_n = START;
                    shift_n = bus.tx_data;
`ifdef UART_TX_PARITY_EN
                    par_n   = ^bus.tx_data;
`endif
                end
            end
            START: begin
                run       = 1'b1;
                bit_cnt_n = '0;
                if (bit_end) state_n = DATA;
            end
            DATA: begin
                run = 1'b1;
                if (bit_end) begin
                    shift_n = shift_reg >> 1;
                    // stop counting at 7 so the counter never wraps inside a frame
                    if (bit_cnt == 3'd7)
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    else
                        bit_cnt_n = bit_cnt + 3'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                run = 1'b1;
                if (bit_end) state_n = STOP;
            end
`endif
            STOP: begin
                run = 1'b1;
                if (bit_end) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n   = IDLE;
                bit_cnt_n = '0;
                shift_n   = '0;
            end
        endcase
        if (run) begin
            clk_cnt_n = tick ? '0 : clk_cnt + 1'b1;
            smp_cnt_n = bit_end ? '0 : tick ? smp_cnt + 1'b1 : smp_cnt;
        end
        // tx is derived from the next state so the line changes on the same edge as the state
        tx_n = 1'b1;
        if (state_n == START)
            tx_n = 1'b0;
        else if (state_n == DATA)
            tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
        else if (state_n == PARITY)
            tx_n = par_n;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            smp_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
            tx_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            clk_cnt   <= clk_cnt_n;
            smp_cnt   <= smp_cnt_n;
            bit_cnt   <= bit_cnt_n;
            shift_reg <= shift_n;
            tx        <= tx_n;
            tx_done   <= done_n;
`ifdef UART_TX_PARITY_EN
            par       <= par_n;
`endif
        end
    end
endmodule

// File: tb/tb_uart_tx_fsm.sv
// tb_uart_tx_fsm: randomized and directed bench for uart_tx_fsm against a frame-level model.
module tb_uart_tx_fsm;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
    localparam logic [10:0] A5_EXP = 11'b10101001010;
    localparam logic [10:0] X55_EXP = 11'b10010101010;
    localparam int FLEN0 = 704;
    localparam int FLEN1 = 176;
`else
    localparam int NB = 10;
    localparam logic [10:0] A5_EXP = 11'b01101001010;
    localparam logic [10:0] X55_EXP = 11'b01010101010;
    localparam int FLEN0 = 640;
    localparam int FLEN1 = 160;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [7:0] dat [2];
    logic [1:0] vld = '0;
    wire  [1:0] rdy, txo, dno;

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        uart_tx_fsm_if u_if ();
        assign u_if.tx_data  = dat[g];
        assign u_if.tx_valid = vld[g];
        assign rdy[g]        = u_if.tx_ready;
        uart_tx_fsm #(.CLKS_PER_SAMPLE(g == 0 ? 4 : 1), .OVERSAMPLE(16)) u_dut (
            .clock(clock),
            .reset(reset),
            .bus(u_if.slave),
            .tx(txo[g]),
            .tx_done(dno[g])
        );
    end

    int n_cmp = 0;
    int n_bad = 0;
    int dones [2];
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int per(input int g);
        return g == 0 ? 64 : 16;
    endfunction

    // frame bits in transmission order, index 0 first on the line
    function automatic logic [10:0] frame(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {2'b11, d, 1'b0};
`endif
    endfunction

    // model: a busy frame lasts NB*period clocks; left counts the clocks still to go
    int          left [2];
    logic [10:0] fr [2];
    logic        done_e [2];
    always @(posedge clock) begin
        for (int g = 0; g < 2; g++) begin
            if (reset) begin
                left[g]   <= 0;
                done_e[g] <= 1'b0;
            end else if (left[g] == 0) begin
                done_e[g] <= 1'b0;
                if (vld[g]) begin
                    fr[g]   <= frame(dat[g]);
                    left[g] <= NB * per(g);
                end
            end else begin
                left[g]   <= left[g] - 1;
                done_e[g] <= left[g] == 1;
            end
        end
    end

    logic e_tx;
    always @(negedge clock) begin
        if (chk_en) begin
            for (int g = 0; g < 2; g++) begin
                e_tx = left[g] == 0 ? 1'b1 : fr[g][(NB * per(g) - left[g]) / per(g)];
                chk($sformatf("tx%0d", g), 32'(txo[g]), 32'(e_tx));
                chk($sformatf("ready%0d", g), 32'(rdy[g]), 32'(left[g] == 0));
                chk($sformatf("done%0d", g), 32'(dno[g]), 32'(done_e[g]));
                if (dno[g]) dones[g]++;
            end
        end
    end

    task automatic wait_ready(input int g);
        int n = 0;
        while (!rdy[g] && n < 5000) begin
            @(negedge clock);
            n++;
        end
        if (!rdy[g]) chk("ready_timeout", 32'(rdy[g]), 32'd1);
    endtask

    task automatic send(input int g, input logic [7:0] d);
        dat[g] = d;
        vld[g] = 1'b1;
        wait_ready(g);
        @(negedge clock);
        vld[g] = 1'b0;
    endtask

    task automatic capture(input int g, input logic [7:0] d, output logic [10:0] mid,
                           output int low, output int doff);
        int p = per(g);
        mid  = '1;
        low  = 0;
        doff = -1;
        dat[g] = d;
        vld[g] = 1'b1;
        wait_ready(g);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            if (c == 0) vld[g] = 1'b0;
            if (c % p == p / 2 && c / p < 11) mid[c / p] = txo[g];
            if (!rdy[g]) low++;
            if (dno[g]) begin
                doff = c;
                break;
            end
        end
        if (doff < 0) chk("done_timeout", 32'(dno[g]), 32'd1);
    endtask

    logic [10:0] mid;
    int low, doff;

    initial begin
        dat[0] = '0;
        dat[1] = '0;
        repeat (3) @(negedge clock);
        reset  = 1'b0;
        chk_en = 1'b1;
        chk("rst_tx", 32'(txo[0]), 32'd1);
        chk("rst_ready", 32'(rdy[0]), 32'd1);
        chk("rst_done", 32'(dno[0]), 32'd0);

        capture(0, 8'hA5, mid, low, doff);
        chk("a5_bits", 32'(mid[NB-1:0]), 32'(A5_EXP[NB-1:0]));
        chk("a5_low", 32'(low), 32'(FLEN0));
        chk("a5_done_off", 32'(doff), 32'(FLEN0));
        capture(0, 8'h07, mid, low, doff);
        chk("07_bit9", 32'(mid[9]), 32'd1);
        chk("07_bit8", 32'(mid[8]), 32'd0);

        repeat (2) @(negedge clock);
        dones[0] = 0;
        dat[0] = 8'h00;
        vld[0] = 1'b1;
        wait_ready(0);
        @(negedge clock);
        dat[0] = 8'hFF;
        wait_ready(0);
        @(negedge clock);
        vld[0] = 1'b0;
        wait_ready(0);
        repeat (5) @(negedge clock);
        chk("b2b_dones", 32'(dones[0]), 32'd2);

        dones[0] = 0;
        send(0, 8'h12);
        repeat (200) @(negedge clock);
        dat[0] = 8'h3C;
        vld[0] = 1'b1;
        @(negedge clock);
        vld[0] = 1'b0;
        wait_ready(0);
        repeat (300) @(negedge clock);
        chk("ignore_dones", 32'(dones[0]), 32'd1);

        dones[0] = 0;
        send(0, 8'h99);
        repeat (299) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("abort_tx", 32'(txo[0]), 32'd1);
        chk("abort_ready", 32'(rdy[0]), 32'd1);
        dat[0] = 8'hC3;
        vld[0] = 1'b1;
        reset  = 1'b1;
        @(negedge clock);
        reset  = 1'b0;
        vld[0] = 1'b0;
        chk("rst_prio_tx", 32'(txo[0]), 32'd1);
        repeat (700) @(negedge clock);
        chk("abort_dones", 32'(dones[0]), 32'd0);
        capture(0, 8'h55, mid, low, doff);
        chk("55_bits", 32'(mid[NB-1:0]), 32'(X55_EXP[NB-1:0]));

        capture(1, 8'h80, mid, low, doff);
        chk("80_bit8", 32'(mid[8]), 32'd1);
        chk("80_bit7", 32'(mid[7]), 32'd0);
        chk("80_done_off", 32'(doff), 32'(FLEN1));
        chk("80_low", 32'(low), 32'(FLEN1));

        for (int i = 0; i < 30; i++) begin
            int g = int'($urandom_range(0, 1));
            repeat ($urandom_range(0, 40)) @(negedge clock);
            send(g, 8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 5 * per(g))) @(negedge clock);
                dat[g] = 8'($urandom);
                vld[g] = 1'b1;
                @(negedge clock);
                vld[g] = 1'b0;
            end
        end
        wait_ready(0);
        wait_ready(1);
        repeat (10) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_fsm.md
UART_TX_FSM -- requirements
Module: uart_tx_fsm

Interface
- REQ-001 Parameter CLKS_PER_SAMPLE, default 4: clock cycles per oversample tick, legal values 1 or more.
- REQ-002 Parameter OVERSAMPLE, default 16: sample ticks per bit. Bit period = CLKS_PER_SAMPLE*OVERSAMPLE clocks (64 by default).
- REQ-003 clock  input  1  Single clock; all state updates on the posedge.
- REQ-004 reset  input  1  Reset, synchronous and active-high.
- REQ-005 tx_data  input  8  Byte to transmit. Sampled only on the accept cycle.
- REQ-006 tx_valid  input  1  Sender requests transmission of tx_data.
- REQ-007 tx_ready  output  1  Block is able to accept a byte (high only in IDLE).
- REQ-008 tx  output  1  Serial line. Idle level is 1.
- REQ-009 tx_done  output  1  One-cycle pulse when the stop bit completes.

Function
- REQ-010 States are IDLE, START, DATA, PARITY, STOP. PARITY exists only when the configuration macro is defined.
- REQ-011 Accept occurs when tx_valid and tx_ready are both high on a posedge. On accept, tx_data is latched into a shift register and the state becomes START.
- REQ-012 tx_valid while not in IDLE is ignored. No byte is queued.
- REQ-013 tx is registered. It is 1 in IDLE, 0 in START, shift_reg[0] in DATA, the parity bit in PARITY, and 1 in STOP.
- REQ-014 tx first goes low in the cycle immediately after the accept edge.
- REQ-015 Every state except IDLE lasts exactly one bit period. Timing uses a clock counter (0..CLKS_PER_SAMPLE-1) that generates a sample tick, and a sample counter (0..OVERSAMPLE-1). A bit ends when the sample counter is at OVERSAMPLE-1 and a tick occurs.
- REQ-016 At the end of each bit, both counters clear.
- REQ-017 DATA sends 8 bits, LSB first. The shift register shifts right and the bit counter increments at each DATA bit end. After the bit counter reaches 7 and that bit ends, the next state is PARITY (or STOP if parity is compiled out).
- REQ-018 The bit counter is 3 bits. It clears in IDLE and START and must never wrap mid-frame.
- REQ-019 At STOP bit end: the state returns to IDLE and tx_done pulses in that same cycle.
- REQ-020 tx_ready is high from the next cycle, so the fastest back-to-back gap is 1 idle clock.
- REQ-021 tx_ready is combinational from state (IDLE). It must never be high while tx is not 1.
- REQ-022 An illegal state encoding recovers to IDLE on the next clock with tx = 1.

Reset
- REQ-023 Reset asserted on a posedge forces: state IDLE, tx = 1, tx_ready = 1 after release, tx_done = 0, all counters 0, shift register 0.
- REQ-024 Reset mid-frame aborts the frame. tx is 1 on the cycle after the reset edge and no tx_done is produced.
- REQ-025 Reset has priority over an accept in the same cycle.

Configuration
- REQ-026 Macro UART_TX_PARITY_EN defined: the PARITY state is inserted between DATA and STOP, with parity = XOR of the latched byte (even parity). The frame is 11 bits.
- REQ-027 Macro undefined: there is no PARITY state or logic, and the frame is 10 bits.

Verification
- REQ-028 Default parameters, parity off, send 0xA5 -> tx over time is 0,1,0,1,0,0,1,0,1,1, each level held 64 clocks. tx_done pulses 640 clocks after the first low clock. tx_ready is low for exactly 640 clocks.
- REQ-029 UART_TX_PARITY_EN, send 0xA5 -> the parity bit is 0 and the frame lasts 704 clocks. Send 0x07 -> the parity bit is 1.
- REQ-030 Hold tx_valid high with 0x00 then 0xFF back-to-back -> two complete frames with a 1-clock tx = 1 gap between them. Exactly two tx_done pulses.
- REQ-031 Pulse tx_valid with 0x3C during DATA -> the byte is ignored, the current frame is unchanged, and there is no second frame.
- REQ-032 Assert reset at clock 300 of a frame -> tx = 1 next cycle, tx_ready = 1, no tx_done. A new send of 0x55 is then transmitted correctly.
- REQ-033 CLKS_PER_SAMPLE = 1, OVERSAMPLE = 16, send 0x80 -> bit period of 16 clocks, the last data bit is 1, and the frame lasts 160 clocks.
